tag_fill_unit: RTL and testbench

- Write side of the L2 tag path: on a lookup miss, selects a victim way, evicts it if dirty, requests the line fill, then writes the new tag/valid/dirty into the tag array that the tag comparators read.
- Sits between the miss detector (downstream of the per-way tag compare) and the next-level memory interface.
- Handles one miss at a time.

---
 rtl/tag_fill_unit.sv | 137 +++++++++++++
 tb/tb_tag_fill_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_fill_unit.sv
// rtl/tag_fill_unit.sv - L2 miss victim selection, writeback, line fill and tag-array write
module tag_fill_unit #(
    parameter int tagBits   = 12,
    parameter int indexBits = 14,
    parameter int ways      = 8,
    parameter int wayBits   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      miss_valid,
    output logic                      miss_ready,
    input  logic [indexBits-1:0]      miss_index,
    input  logic [tagBits-1:0]        miss_tag,
    input  logic                      miss_is_write,
    input  logic [ways-1:0]           set_valid,
    input  logic [ways-1:0]           set_dirty,
    input  logic [ways*tagBits-1:0]   set_tags,
    input  logic [wayBits-1:0]        lru_way,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [tagBits-1:0]        wb_tag,
    output logic [indexBits-1:0]      wb_index,
    output logic                      fill_valid,
    input  logic                      fill_ready,
    output logic [tagBits-1:0]        fill_tag,
    output logic [indexBits-1:0]      fill_index,
    input  logic                      fill_done,
    output logic                      tag_we,
    output logic [indexBits-1:0]      tag_we_index,
    output logic [wayBits-1:0]        tag_we_way,
    output logic [tagBits-1:0]        tag_we_tag,
    output logic                      tag_we_dirty,
    output logic                      fill_complete,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        UPDATE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [indexBits-1:0] index_q, index_d;
    logic [tagBits-1:0]   tag_q, tag_d;
    logic                 is_write_q, is_write_d;
    logic [wayBits-1:0]   way_q, way_d;
    logic [tagBits-1:0]   victim_tag_q, victim_tag_d;

    logic [wayBits-1:0]   victim_way;
    logic                 victim_dirty;
    logic [tagBits-1:0]   victim_tag;
    logic                 found_invalid;
    logic                 accept;

    // An invalid way always wins over the replacement policy, so only an lru victim can be dirty.
    always_comb begin
        victim_way    = lru_way;
        found_invalid = 1'b0;
        for (int w = 0; w < ways; w++) begin
            if (!found_invalid && !set_valid[w]) begin
                victim_way    = wayBits'(w);
                found_invalid = 1'b1;
            end
        end
        victim_dirty = !found_invalid && set_dirty[lru_way];
        victim_tag   = set_tags[int'(lru_way)*tagBits +: tagBits];
    end

    assign accept = (state_q == IDLE) && miss_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            tag_q        <= '0;
            is_write_q   <= 1'b0;
            way_q        <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            is_write_q   <= is_write_d;
            way_q        <= way_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss_valid) state_d = victim_dirty ? WB_REQ : FILL_REQ;
            WB_REQ:    if (wb_ready) state_d = FILL_REQ;
            FILL_REQ:  if (fill_ready) state_d = FILL_WAIT;
            FILL_WAIT: if (fill_done) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        index_d      = index_q;
        tag_d        = tag_q;
        is_write_d   = is_write_q;
        way_d        = way_q;
        victim_tag_d = victim_tag_q;
        if (accept) begin
            index_d      = miss_index;
            tag_d        = miss_tag;
            is_write_d   = miss_is_write;
            way_d        = victim_way;
            victim_tag_d = victim_tag;
        end
    end

    // Every output is a decode of registered state or a captured register.
    always_comb begin
        miss_ready    = (state_q == IDLE);
        busy          = (state_q != IDLE);
        wb_valid      = (state_q == WB_REQ);
        fill_valid    = (state_q == FILL_REQ);
        tag_we        = (state_q == UPDATE);
        fill_complete = (state_q == UPDATE);
        wb_tag        = victim_tag_q;
        wb_index      = index_q;
        fill_tag      = tag_q;
        fill_index    = index_q;
        tag_we_index  = index_q;
        tag_we_way    = way_q;
        tag_we_tag    = tag_q;
        tag_we_dirty  = is_write_q;
    end

endmodule

// File: tb/tb_tag_fill_unit.sv
// tb/tb_tag_fill_unit.sv - randomized and directed self-checking bench for tag_fill_unit
module tb_tag_fill_unit;

    logic        clk;
    logic        reset_n;
    logic        miss_valid;
    logic        miss_ready;
    logic [13:0] miss_index;
    logic [11:0] miss_tag;
    logic        miss_is_write;
    logic [7:0]  set_valid;
    logic [7:0]  set_dirty;
    logic [95:0] set_tags;
    logic [2:0]  lru_way;
    logic        wb_valid;
    logic        wb_ready;
    logic [11:0] wb_tag;
    logic [13:0] wb_index;
    logic        fill_valid;
    logic        fill_ready;
    logic [11:0] fill_tag;
    logic [13:0] fill_index;
    logic        fill_done;
    logic        tag_we;
    logic [13:0] tag_we_index;
    logic [2:0]  tag_we_way;
    logic [11:0] tag_we_tag;
    logic        tag_we_dirty;
    logic        fill_complete;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    tag_fill_unit dut (
        .clk(clk), .reset_n(reset_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_index(miss_index), .miss_tag(miss_tag), .miss_is_write(miss_is_write),
        .set_valid(set_valid), .set_dirty(set_dirty), .set_tags(set_tags), .lru_way(lru_way),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_index(wb_index),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_tag(fill_tag),
        .fill_index(fill_index), .fill_done(fill_done),
        .tag_we(tag_we), .tag_we_index(tag_we_index), .tag_we_way(tag_we_way),
        .tag_we_tag(tag_we_tag), .tag_we_dirty(tag_we_dirty),
        .fill_complete(fill_complete), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference victim choice: first invalid way in ascending order, else the policy's way.
    function automatic void model_victim(input logic [7:0] v, input logic [7:0] d,
                                         input logic [2:0] lru, output int way, output bit dirty);
        int inv[$];
        for (int i = 0; i < 8; i++) if (!v[i]) inv.push_back(i);
        if (inv.size() > 0) begin
            way   = inv[0];
            dirty = 1'b0;
        end else begin
            way   = int'(lru);
            dirty = d[lru];
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_miss_ready"}, miss_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_wb_valid"}, wb_valid, 0);
        check_eq({tag, "_fill_valid"}, fill_valid, 0);
        check_eq({tag, "_tag_we"}, tag_we, 0);
        check_eq({tag, "_fill_complete"}, fill_complete, 0);
    endtask

    task automatic run_miss(input logic [11:0] mtag, input logic [13:0] midx, input bit mw,
                            input logic [7:0] sv, input logic [7:0] sd, input logic [95:0] stags,
                            input logic [2:0] lru, input int wb_stall, input int fill_stall,
                            input int done_delay, input bit stray, input bit hold, input bit abort);
        int exp_way, exp_lat, wb_cyc, fill_cyc, wb_hs, fill_hs, wait_cyc;
        bit exp_dirty, in_wait, done;
        logic [11:0] exp_wbtag;
        model_victim(sv, sd, lru, exp_way, exp_dirty);
        exp_wbtag = stags[exp_way*12 +: 12];
        exp_lat   = 3 + fill_stall + done_delay + (exp_dirty ? 1 + wb_stall : 0);
        wb_cyc = 0; fill_cyc = 0; wb_hs = 0; fill_hs = 0; wait_cyc = 0;
        in_wait = 0; done = 0;

        @(negedge clk);
        check_eq("pre_miss_ready", miss_ready, 1);
        miss_valid = 1'b1; miss_tag = mtag; miss_index = midx; miss_is_write = mw;
        set_valid = sv; set_dirty = sd; set_tags = stags; lru_way = lru;
        wb_ready = 0; fill_ready = 0; fill_done = 0;
        @(negedge clk);
        if (!hold) begin
            miss_valid = 1'b0;
            miss_tag = 12'($urandom); miss_index = 14'($urandom); miss_is_write = 1'($urandom);
            set_valid = 8'($urandom); set_dirty = 8'($urandom);
            set_tags = {$urandom, $urandom, $urandom}; lru_way = 3'($urandom);
        end

        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            check_eq("busy", busy, 1);
            check_eq("miss_ready_low", miss_ready, 0);
            wb_ready = 0; fill_ready = 0; fill_done = 0;
            if (in_wait) begin
                if (abort) begin
                    reset_n = 1'b0;
                    #1;
                    check_idle_outputs("abort");
                    @(negedge clk);
                    reset_n   = 1'b1;
                    fill_done = 1'b1;
                    @(negedge clk);
                    fill_done = 1'b0;
                    check_idle_outputs("post_abort");
                    @(negedge clk);
                    check_eq("post_abort_tag_we", tag_we, 0);
                    return;
                end
                if (wait_cyc == done_delay) fill_done = 1'b1;
                wait_cyc++;
            end
            if (wb_valid) begin
                check_eq("wb_tag", wb_tag, exp_wbtag);
                check_eq("wb_index", wb_index, midx);
                wb_cyc++;
                if (wb_cyc > wb_stall) begin wb_ready = 1'b1; wb_hs++; end
            end
            if (fill_valid) begin
                check_eq("fill_tag", fill_tag, mtag);
                check_eq("fill_index", fill_index, midx);
                check_eq("fill_after_wb", wb_hs, exp_dirty);
                fill_cyc++;
                if (stray) fill_done = 1'b1;
                if (fill_cyc > fill_stall) begin fill_ready = 1'b1; fill_hs++; in_wait = 1; end
            end
            if (tag_we) begin
                check_eq("tag_we_way", tag_we_way, exp_way);
                check_eq("tag_we_tag", tag_we_tag, mtag);
                check_eq("tag_we_index", tag_we_index, midx);
                check_eq("tag_we_dirty", tag_we_dirty, mw);
                check_eq("fill_complete", fill_complete, 1);
                check_eq("latency", cyc, exp_lat);
                check_eq("wb_cycles", wb_cyc, exp_dirty ? wb_stall + 1 : 0);
                check_eq("fill_cycles", fill_cyc, fill_stall + 1);
                check_eq("fill_handshakes", fill_hs, 1);
                miss_valid = 1'b0;
                done = 1;
            end else begin
                check_eq("fill_complete_low", fill_complete, 0);
            end
            @(negedge clk);
        end
        check_eq("completed_in_budget", done, 1);
        fill_done = 0; wb_ready = 0; fill_ready = 0;
        check_idle_outputs("after_update");
    endtask

    initial begin
        reset_n = 0; miss_valid = 0; miss_index = 0; miss_tag = 0; miss_is_write = 0;
        set_valid = 0; set_dirty = 0; set_tags = 0; lru_way = 0;
        wb_ready = 0; fill_ready = 0; fill_done = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1;

        @(negedge clk);
        fill_done = 1;
        @(negedge clk);
        fill_done = 0;
        check_idle_outputs("stray_idle");

        run_miss(12'hABC, 14'h0010, 0, 8'b0000_0011, 8'h00, {8{12'h555}}, 3'd5,
                 0, 0, 0, 0, 0, 0);
        run_miss(12'h7E1, 14'h2222, 1, 8'hFF, 8'b0010_0000,
                 {12'h0, 12'h0, 12'h123, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}, 3'd5,
                 0, 0, 0, 0, 0, 0);
        run_miss(12'h3C4, 14'h1ABC, 1, 8'hFF, 8'hFF, {$urandom, $urandom, $urandom}, 3'd7,
                 4, 3, 0, 0, 0, 0);
        run_miss(12'h9F0, 14'h0333, 0, 8'hFF, 8'h00, {$urandom, $urandom, $urandom}, 3'd1,
                 0, 2, 2, 1, 0, 0);
        run_miss(12'h111, 14'h0444, 1, 8'hFF, 8'h08, {$urandom, $urandom, $urandom}, 3'd3,
                 1, 0, 2, 0, 0, 1);
        run_miss(12'h222, 14'h0555, 0, 8'b1110_1111, 8'hFF, {$urandom, $urandom, $urandom}, 3'd0,
                 0, 0, 0, 0, 0, 0);
        run_miss(12'hFFF, 14'h3FFF, 1, 8'hFF, 8'h01, {$urandom, $urandom, $urandom}, 3'd0,
                 1, 1, 1, 1, 1, 0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] sv;
            sv = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            run_miss(12'($urandom), 14'($urandom), 1'($urandom), sv, 8'($urandom),
                     {$urandom, $urandom, $urandom}, 3'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
